// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: operand-select
// encodings and the memory-wait FSM state.
package pipe_pkg;

    localparam logic [1:0] SEL_REG = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_fwd_sel.sv
// One-operand forwarding comparator: picks the youngest in-flight producer of
// src_i, MEM ahead of WB; register 0 never forwards.
module pipe_fwd_sel
    import pipe_pkg::*;
#(
    parameter int RW     = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic [RW-1:0] src_i,
    input  logic          use_i,
    input  logic          mem_wb_en_i,
    input  logic [RW-1:0] mem_dst_i,
    input  logic          wb_wb_en_i,
    input  logic [RW-1:0] wb_dst_i,
    output logic [1:0]    sel_o
);

    logic src_nz;
    assign src_nz = (src_i != '0);

    always_comb begin
        sel_o = SEL_REG;
        if (FWD_EN && use_i && src_nz) begin
            if (mem_wb_en_i && (mem_dst_i == src_i))
                sel_o = SEL_MEM;
            else if (wb_wb_en_i && (wb_dst_i == src_i))
                sel_o = SEL_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard, forwarding and stall controller for the five-stage pipeline, with a
// variable-latency data-memory wait FSM that aborts after TIMEOUT cycles.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int RW      = 5,
    parameter bit FWD_EN  = 1'b1,
    parameter int TIMEOUT = 16,
    parameter int TW      = 8,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] id_src1,
    input  logic [RW-1:0] id_src2,
    input  logic          id_two_src,
    input  logic [RW-1:0] ex_src1,
    input  logic [RW-1:0] ex_src2,
    input  logic          ex_two_src,
    input  logic [RW-1:0] ex_st_src,
    input  logic          ex_wb_en,
    input  logic          ex_mem_read,
    input  logic [RW-1:0] ex_dst,
    input  logic          mem_wb_en,
    input  logic [RW-1:0] mem_dst,
    input  logic          wb_wb_en,
    input  logic [RW-1:0] wb_dst,
    input  logic          br_taken,
    input  logic          mem_req,
    input  logic          mem_ready,
    input  logic          perf_clr,
    output logic [1:0]    val1_sel,
    output logic [1:0]    val2_sel,
    output logic [1:0]    st_val_sel,
    output logic          freeze_front,
    output logic          bubble_ex,
    output logic          freeze_back,
    output logic          bubble_wb,
    output logic          flush,
    output logic          mem_err,
    output logic [CW-1:0] stall_cnt
);

    localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

    state_e        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          mem_err_q, set_err;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic          mwait;

    // ---------------- hazard detection ----------------
    logic id1_nz, id2_nz, hit_ex, hit_mem, hz;
    assign id1_nz  = (id_src1 != '0);
    assign id2_nz  = (id_src2 != '0) && id_two_src;
    assign hit_ex  = (id1_nz && (id_src1 == ex_dst))  || (id2_nz && (id_src2 == ex_dst));
    assign hit_mem = (id1_nz && (id_src1 == mem_dst)) || (id2_nz && (id_src2 == mem_dst));
    assign hz = FWD_EN ? (ex_wb_en && ex_mem_read && hit_ex)
                       : ((ex_wb_en && hit_ex) || (mem_wb_en && hit_mem));

    // ---------------- forwarding selects ----------------
    logic [2:0][RW-1:0] fwd_src;
    logic [2:0]         fwd_use;
    logic [2:0][1:0]    fwd_sel;
    assign fwd_src = {ex_st_src, ex_src2, ex_src1};
    assign fwd_use = {1'b1, ex_two_src, 1'b1};

    for (genvar g = 0; g < 3; g++) begin : g_fwd
        pipe_fwd_sel #(.RW(RW), .FWD_EN(FWD_EN)) u_sel (
            .src_i       (fwd_src[g]),
            .use_i       (fwd_use[g]),
            .mem_wb_en_i (mem_wb_en),
            .mem_dst_i   (mem_dst),
            .wb_wb_en_i  (wb_wb_en),
            .wb_dst_i    (wb_dst),
            .sel_o       (fwd_sel[g])
        );
    end

    // ---------------- memory wait FSM ----------------
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        set_err = 1'b0;
        mwait   = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d = WAIT;
                    tcnt_d  = TW'(1);
                    mwait   = 1'b1;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else if (tcnt_q == TMO) begin
                    // Abort: release with whatever is on the bus.
                    state_d = RUN;
                    set_err = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                    mwait  = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // ---------------- pipeline controls ----------------
    logic flush_c, ff_c, bx_c;
    assign flush_c = br_taken && !mwait;
    assign ff_c    = mwait || (hz && !flush_c);
    assign bx_c    = hz && !flush_c && !mwait;

    assign freeze_front = !rst && ff_c;
    assign bubble_ex    = !rst && bx_c;
    assign freeze_back  = !rst && mwait;
    assign bubble_wb    = !rst && mwait;
    assign flush        = !rst && flush_c;
    assign val1_sel     = rst ? SEL_REG : fwd_sel[0];
    assign val2_sel     = rst ? SEL_REG : fwd_sel[1];
    assign st_val_sel   = rst ? SEL_REG : fwd_sel[2];

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr)
            stall_cnt_d = '0;
        else if (ff_c && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            tcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            mem_err_q   <= mem_err_q || set_err;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a forwarding build (TIMEOUT=4, 4-bit stall
// counter) and a no-forwarding build driven from the same directed vectors.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_src1, id_src2, ex_src1, ex_src2, ex_st_src, ex_dst, mem_dst, wb_dst;
    logic       id_two_src, ex_two_src, ex_wb_en, ex_mem_read, mem_wb_en, wb_wb_en;
    logic       br_taken, mem_req, mem_ready, perf_clr;

    logic [1:0] val1_sel, val2_sel, st_val_sel;
    logic       freeze_front, bubble_ex, freeze_back, bubble_wb, flush, mem_err;
    logic [3:0] stall_cnt;

    logic [1:0] val1_sel_n, val2_sel_n, st_val_sel_n;
    logic       freeze_front_n, bubble_ex_n, freeze_back_n, bubble_wb_n, flush_n, mem_err_n;
    logic [3:0] stall_cnt_n;

    pipe_ctrl #(.RW(5), .FWD_EN(1'b1), .TIMEOUT(4), .TW(8), .CW(4)) u_dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_two_src(ex_two_src), .ex_st_src(ex_st_src),
        .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
        .mem_wb_en(mem_wb_en), .mem_dst(mem_dst), .wb_wb_en(wb_wb_en), .wb_dst(wb_dst),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready), .perf_clr(perf_clr),
        .val1_sel(val1_sel), .val2_sel(val2_sel), .st_val_sel(st_val_sel),
        .freeze_front(freeze_front), .bubble_ex(bubble_ex), .freeze_back(freeze_back),
        .bubble_wb(bubble_wb), .flush(flush), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.RW(5), .FWD_EN(1'b0), .TIMEOUT(4), .TW(8), .CW(4)) u_nofwd (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_two_src(ex_two_src), .ex_st_src(ex_st_src),
        .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
        .mem_wb_en(mem_wb_en), .mem_dst(mem_dst), .wb_wb_en(wb_wb_en), .wb_dst(wb_dst),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready), .perf_clr(perf_clr),
        .val1_sel(val1_sel_n), .val2_sel(val2_sel_n), .st_val_sel(st_val_sel_n),
        .freeze_front(freeze_front_n), .bubble_ex(bubble_ex_n), .freeze_back(freeze_back_n),
        .bubble_wb(bubble_wb_n), .flush(flush_n), .mem_err(mem_err_n), .stall_cnt(stall_cnt_n)
    );

    typedef struct {
        logic       ff, bx, fb, bw, fl;
        logic [1:0] v1, v2, st;
        logic       merr;
        logic [3:0] cnt;
        logic       chk_reg;
        logic       ff0, bx0;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [3:0] exp_cnt  = 4'd0;
    logic       exp_merr = 1'b0;
    logic       chk_reg  = 1'b0;

    task automatic ck(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Monitor: compares every cycle for which a vector was issued.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            ck("freeze_front", {7'd0, freeze_front}, {7'd0, m_e.ff});
            ck("bubble_ex",    {7'd0, bubble_ex},    {7'd0, m_e.bx});
            ck("freeze_back",  {7'd0, freeze_back},  {7'd0, m_e.fb});
            ck("bubble_wb",    {7'd0, bubble_wb},    {7'd0, m_e.bw});
            ck("flush",        {7'd0, flush},        {7'd0, m_e.fl});
            ck("sels",         {2'd0, val1_sel, val2_sel, st_val_sel},
                               {2'd0, m_e.v1, m_e.v2, m_e.st});
            ck("nofwd_freeze_front", {7'd0, freeze_front_n}, {7'd0, m_e.ff0});
            ck("nofwd_bubble_ex",    {7'd0, bubble_ex_n},    {7'd0, m_e.bx0});
            ck("nofwd_sels", {2'd0, val1_sel_n, val2_sel_n, st_val_sel_n}, 8'd0);
            if (m_e.chk_reg) begin
                ck("mem_err",   {7'd0, mem_err},   {7'd0, m_e.merr});
                ck("stall_cnt", {4'd0, stall_cnt}, {4'd0, m_e.cnt});
            end
        end
    end

    task automatic clr_in();
        id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
        ex_src1 = '0; ex_src2 = '0; ex_two_src = 1'b0; ex_st_src = '0;
        ex_wb_en = 1'b0; ex_mem_read = 1'b0; ex_dst = '0;
        mem_wb_en = 1'b0; mem_dst = '0; wb_wb_en = 1'b0; wb_dst = '0;
        br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; perf_clr = 1'b0;
    endtask

    // Issue one cycle: inputs are already applied; push expectations, advance.
    task automatic v(input logic ff, input logic bx, input logic fb, input logic fl,
                     input logic [1:0] v1, input logic [1:0] v2, input logic [1:0] st,
                     input logic ff0, input logic bx0);
        exp_t e;
        e.ff = ff; e.bx = bx; e.fb = fb; e.bw = fb; e.fl = fl;
        e.v1 = v1; e.v2 = v2; e.st = st;
        e.merr = exp_merr; e.cnt = exp_cnt; e.chk_reg = chk_reg;
        e.ff0 = ff0; e.bx0 = bx0;
        q.push_back(e);
        if (rst || perf_clr) exp_cnt = 4'd0;
        else if ((ff || fb) && exp_cnt != 4'hf) exp_cnt = exp_cnt + 4'd1;
        @(posedge clk); #1;
    endtask

    task automatic load_use(input logic [4:0] r);
        ex_wb_en = 1'b1; ex_mem_read = 1'b1; ex_dst = r; id_src1 = r;
    endtask

    initial begin
        clr_in();
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset masks every combinational output even with hazards present.
        load_use(5'd3); br_taken = 1'b1; mem_req = 1'b1;
        mem_wb_en = 1'b1; mem_dst = 5'd4; ex_src1 = 5'd4;
        v(0,0,0,0, 0,0,0, 0,0);
        chk_reg = 1'b1;
        v(0,0,0,0, 0,0,0, 0,0);
        rst = 1'b0; clr_in();
        v(0,0,0,0, 0,0,0, 0,0);

        // Load-use: one stall, then the load result forwards from MEM.
        load_use(5'd3);
        v(1,1,0,0, 0,0,0, 1,1);
        clr_in(); mem_wb_en = 1'b1; mem_dst = 5'd3; ex_src1 = 5'd3;
        v(0,0,0,0, 1,0,0, 0,0);

        // Double forward: MEM beats WB on every operand.
        clr_in(); mem_wb_en = 1'b1; mem_dst = 5'd4; wb_wb_en = 1'b1; wb_dst = 5'd4;
        ex_src1 = 5'd4; ex_src2 = 5'd4; ex_two_src = 1'b1; ex_st_src = 5'd4;
        v(0,0,0,0, 1,1,1, 0,0);
        // WB only; second operand unused.
        mem_dst = 5'd7; ex_two_src = 1'b0;
        v(0,0,0,0, 2,0,2, 0,0);
        // Register 0 never matches.
        clr_in(); mem_wb_en = 1'b1; wb_wb_en = 1'b1; load_use(5'd0);
        v(0,0,0,0, 0,0,0, 0,0);

        // id_src2 only counts when id_two_src.
        clr_in(); ex_wb_en = 1'b1; ex_mem_read = 1'b1; ex_dst = 5'd6;
        id_src2 = 5'd6; id_src1 = 5'd1;
        v(0,0,0,0, 0,0,0, 0,0);
        id_two_src = 1'b1;
        v(1,1,0,0, 0,0,0, 1,1);

        // ALU producers stall only the no-forwarding build.
        clr_in(); mem_wb_en = 1'b1; mem_dst = 5'd5; id_src1 = 5'd5;
        v(0,0,0,0, 0,0,0, 1,1);
        clr_in(); ex_wb_en = 1'b1; ex_dst = 5'd5; id_src1 = 5'd5;
        v(0,0,0,0, 0,0,0, 1,1);

        // Branch with load-use: flush wins, no bubble; clear counter.
        clr_in(); load_use(5'd3); br_taken = 1'b1; perf_clr = 1'b1;
        v(0,0,0,1, 0,0,0, 0,0);

        // Memory ready 3 cycles after issue -> 3 frozen cycles.
        clr_in(); mem_req = 1'b1;
        v(1,0,1,0, 0,0,0, 1,0);
        load_use(5'd3); br_taken = 1'b1;          // masked by the wait
        v(1,0,1,0, 0,0,0, 1,0);
        clr_in(); mem_req = 1'b1;
        v(1,0,1,0, 0,0,0, 1,0);
        mem_ready = 1'b1;
        v(0,0,0,0, 0,0,0, 0,0);
        clr_in();
        v(0,0,0,0, 0,0,0, 0,0);
        mem_req = 1'b1; mem_ready = 1'b1;         // same-cycle completion
        v(0,0,0,0, 0,0,0, 0,0);

        // Timeout: 4 frozen cycles, then release with mem_err sticky.
        clr_in(); mem_req = 1'b1;
        repeat (4) v(1,0,1,0, 0,0,0, 1,0);
        br_taken = 1'b1;
        v(0,0,0,1, 0,0,0, 0,0);
        clr_in(); perf_clr = 1'b1; exp_merr = 1'b1;
        v(0,0,0,0, 0,0,0, 0,0);
        clr_in();
        v(0,0,0,0, 0,0,0, 0,0);

        // Counter saturates at all ones.
        load_use(5'd9);
        for (int i = 0; i < 17; i++) v(1,1,0,0, 0,0,0, 1,1);
        clr_in();
        v(0,0,0,0, 0,0,0, 0,0);

        // Reset during WAIT: back to RUN, mem_err cleared.
        mem_req = 1'b1;
        v(1,0,1,0, 0,0,0, 1,0);
        rst = 1'b1;
        v(0,0,0,0, 0,0,0, 0,0);
        rst = 1'b0; clr_in(); exp_merr = 1'b0;
        v(0,0,0,0, 0,0,0, 0,0);
        mem_req = 1'b1; mem_ready = 1'b1;
        v(0,0,0,0, 0,0,0, 0,0);
        clr_in();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d vectors left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised hazard, forwarding and stall controller for the five-stage pipeline. It merges load-use detection and EX-stage forwarding into one block and adds two capabilities: a compile-time switch for forwarding on/off, and a variable-latency data-memory wait state machine with timeout. It sits beside the pipeline registers and drives their freeze, bubble and flush controls, plus the EX operand mux selects.

## Interface
- RW, 5: register-address width.
- FWD_EN, 1: 1 = forwarding on, stall only on load-use; 0 = stall on any RAW hazard, all selects 0.
- TIMEOUT, 16: maximum memory wait cycles before abort, 1..2^TW-1.
- TW, 8: timeout counter width.
- CW, 16: stall performance counter width.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_src1, id_src2  in  RW  source registers of the instruction in ID.
- id_two_src  in  1  the ID instruction reads id_src2.
- ex_src1, ex_src2  in  RW  source registers of the instruction in EX.
- ex_two_src  in  1  the EX instruction reads ex_src2.
- ex_st_src  in  RW  store-data register of the instruction in EX.
- ex_wb_en, ex_mem_read  in  1  EX instruction writes back / is a load.
- ex_dst  in  RW  EX destination register.
- mem_wb_en  in  1  MEM instruction writes back.
- mem_dst  in  RW  MEM destination register.
- wb_wb_en  in  1  WB instruction writes back.
- wb_dst  in  RW  WB destination register.
- br_taken  in  1  branch resolved taken in EX.
- mem_req  in  1  MEM stage issues a data-memory access this cycle.
- mem_ready  in  1  memory completes the access this cycle.
- perf_clr  in  1  clear stall_cnt.
- val1_sel, val2_sel, st_val_sel  out  2  operand source: 0 = register file, 1 = MEM ALU result, 2 = WB write value.
- freeze_front  out  1  hold PC and the IF/ID register.
- bubble_ex  out  1  load a NOP into ID/EX.
- freeze_back  out  1  hold ID/EX and EX/MEM, and stop PC and IF/ID.
- bubble_wb  out  1  load a NOP into MEM/WB.
- flush  out  1  clear IF/ID and ID/EX (taken branch).
- mem_err  out  1  sticky flag: memory timeout occurred.
- stall_cnt  out  CW  count of cycles with any freeze asserted; saturating.

## Operation
- Register 0 never matches, for either hazard or forwarding.
- Hazard detection (hz) compares id_src1, and id_src2 only when id_two_src, against the EX and MEM destinations.
  - FWD_EN=1: hz = ex_wb_en & ex_mem_read & (ex_dst matches).
  - FWD_EN=0: hz = (ex_wb_en & ex_dst matches) | (mem_wb_en & mem_dst matches).
- Forwarding (FWD_EN=1) is evaluated per operand:
  - Select 1 if mem_wb_en and mem_dst equals the source.
  - Else select 2 if wb_wb_en and wb_dst equals the source.
  - Else select 0.
  - MEM takes priority over WB.
  - val2_sel is forced to 0 when !ex_two_src.
  - st_val_sel is computed from ex_st_src.
- The FSM has two states, RUN and WAIT, with a timeout counter tcnt.
  - RUN: if mem_req & !mem_ready, go to WAIT with tcnt = 1.
  - WAIT: if mem_ready, go to RUN.
  - WAIT: else if tcnt == TIMEOUT, go to RUN and set mem_err.
  - WAIT: else tcnt++.
- mwait = (RUN & mem_req & !mem_ready) | (WAIT & !mem_ready & tcnt != TIMEOUT).
- Output equations:
  - freeze_back = mwait.
  - bubble_wb = mwait.
  - flush = br_taken & !mwait.
  - freeze_front = mwait | (hz & !flush).
  - bubble_ex = hz & !flush & !mwait.
- Simultaneous events:
  - Branch and hazard: the flush wins and no bubble is inserted.
  - A memory wait masks both: the EX state is held and re-evaluated when released.
- A timeout abort releases the pipeline with whatever data is on the bus. mem_err stays set until rst.
- stall_cnt increments when freeze_front | freeze_back and saturates at all ones. perf_clr takes priority over the increment.

## Timing
- All freeze, bubble, flush and select outputs are combinational, in the same cycle as their inputs.
- State, tcnt, mem_err and stall_cnt are registered.
- Reset values: state RUN, tcnt 0, mem_err 0, stall_cnt 0.
- While rst is high, all combinational outputs are forced to 0.
- Load-use costs exactly 1 stall cycle.
- A memory access completing N cycles after issue freezes the back end for N cycles; mem_ready in the issue cycle costs 0.
- Timeout: the back end is frozen for exactly TIMEOUT cycles. mem_err reads 1 from the following cycle.
- rst during WAIT returns to RUN on the next edge; no pending state survives.

## Structure
- Shared package pipe_pkg:
  - Select encodings SEL_REG = 0, SEL_MEM = 1, SEL_WB = 2.
  - FSM state enum {RUN, WAIT}.
- One sub-module, pipe_fwd_sel: a combinational one-operand priority comparator, instantiated three times; with FWD_EN=0 it is tied to SEL_REG.
- Hazard logic, FSM and counters stay in pipe_ctrl.

## Test plan
- Load-use: EX is a load to r3, ID reads r3 -> freeze_front = 1 and bubble_ex = 1 for exactly 1 cycle; next cycle val1_sel = 1.
- Double forward: mem_dst = 4 and wb_dst = 4 both enabled, ex_src1 = 4 -> val1_sel = 1. Source r0 with mem_dst = 0 -> select 0 and no stall.
- FWD_EN=0 build: ALU write to r5 in MEM, ID reads r5 -> 1 stall cycle, all selects 0.
- mem_req with mem_ready after 3 cycles -> freeze_back = 1 for 3 cycles, stall_cnt = 3, state RUN afterwards.
- TIMEOUT = 4 with mem_ready never asserted -> 4 frozen cycles, then release, mem_err = 1 sticky; perf_clr zeroes stall_cnt only.
- br_taken together with a load-use hazard -> flush = 1, bubble_ex = 0, freeze_front = 0. br_taken during WAIT -> flush = 0 until release.
